// File: rtl/z80_bus_responder.sv
// Z80 bus-target responder. It registers the CPU strobes and classifies each
// memory, IO or interrupt-acknowledge cycle. Every access becomes a single
// request/ack handshake to the backend. The CPU is held with nWAIT until the
// backend answers or the timeout fires. Read data or the IM2 vector is then
// driven back onto D, and nINT is generated from the pending-interrupt flag.
module z80_bus_responder #(
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        nWAIT,
  output logic        nINT,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  input  logic        int_req,
  input  logic [7:0]  int_vector,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] MIN_W   = 8'(MIN_WAIT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [5:0]  strb_q, strb_d;
  logic        armed_q, armed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_held_q, ack_held_d;
  logic [7:0]  rdata_held_q, rdata_held_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_io_q, bus_io_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        nint_q, nint_d;
  logic        timeout_q, timeout_d;
  logic        inta_entry_s;

  // Registered strobes and the cycle class decoded from them
  logic s_m1_s, s_mreq_s, s_iorq_s, s_rd_s, s_wr_s, s_rfsh_s;
  logic all_high_s;
  logic cls_inta_s, cls_mrd_s, cls_mwr_s, cls_iord_s, cls_iowr_s, cls_access_s;
  assign {s_m1_s, s_mreq_s, s_iorq_s, s_rd_s, s_wr_s, s_rfsh_s} = strb_q;
  assign strb_d       = {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH};
  assign all_high_s   = &strb_q;
  assign cls_inta_s   = ~s_iorq_s & ~s_m1_s;
  assign cls_mrd_s    = ~s_mreq_s & ~s_rd_s & s_rfsh_s;
  assign cls_mwr_s    = ~s_mreq_s & ~s_wr_s;
  assign cls_iord_s   = ~s_iorq_s & ~s_rd_s;
  assign cls_iowr_s   = ~s_iorq_s & ~s_wr_s;
  assign cls_access_s = cls_mrd_s | cls_mwr_s | cls_iord_s | cls_iowr_s;

  // Raw strobes let nWAIT go low before the registered pipeline catches up
  logic raw_inta_s, raw_access_s, wait_s;
  assign raw_inta_s   = ~nIORQ & ~nM1;
  assign raw_access_s = (~nMREQ & ~nRD & nRFSH) | (~nMREQ & ~nWR) |
                        (~nIORQ & ~nRD) | (~nIORQ & ~nWR);
  assign wait_s = ((state_q == ST_IDLE) & armed_q & raw_access_s & ~raw_inta_s) |
                  (state_q == ST_REQ) | (state_q == ST_WAIT);

  // Wait-state bookkeeping: an early ack is remembered until MIN_WAIT is met
  logic       ack_seen_s, min_reached_s;
  logic [7:0] ack_data_s;
  assign ack_seen_s    = bus_ack | ack_held_q;
  assign ack_data_s    = bus_ack ? bus_rdata : rdata_held_q;
  assign min_reached_s = ({1'b0, cnt_q} + 9'd1) > {1'b0, MIN_W};

  assign nWAIT     = ~wait_s;
  assign D_out     = d_out_q;
  assign D_oe      = d_oe_q;
  assign nINT      = nint_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_io    = bus_io_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign timeout   = timeout_q;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      strb_q       <= 6'b000000;
      armed_q      <= 1'b0;
      cnt_q        <= 8'd0;
      ack_held_q   <= 1'b0;
      rdata_held_q <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_io_q     <= 1'b0;
      bus_addr_q   <= 16'd0;
      bus_wdata_q  <= 8'd0;
      d_out_q      <= 8'd0;
      d_oe_q       <= 1'b0;
      nint_q       <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      strb_q       <= strb_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      ack_held_q   <= ack_held_d;
      rdata_held_q <= rdata_held_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_io_q     <= bus_io_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      nint_q       <= nint_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic for the cycle FSM, handshake outputs and interrupt flag
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    ack_held_d   = ack_held_q;
    rdata_held_d = rdata_held_q;
    bus_req_d    = 1'b0;
    bus_we_d     = bus_we_q;
    bus_io_d     = bus_io_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    timeout_d    = 1'b0;
    inta_entry_s = 1'b0;

    if (all_high_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && cls_inta_s) begin
          state_d      = ST_HOLD;
          armed_d      = 1'b0;
          d_out_d      = int_vector;
          d_oe_d       = 1'b1;
          inta_entry_s = 1'b1;
        end else if (armed_q && cls_access_s) begin
          state_d     = ST_REQ;
          armed_d     = 1'b0;
          bus_req_d   = 1'b1;
          bus_addr_d  = A;
          bus_wdata_d = D_in;
          if (cls_mrd_s) begin
            bus_we_d = 1'b0;
            bus_io_d = 1'b0;
          end else if (cls_mwr_s) begin
            bus_we_d = 1'b1;
            bus_io_d = 1'b0;
          end else if (cls_iord_s) begin
            bus_we_d = 1'b0;
            bus_io_d = 1'b1;
          end else begin
            bus_we_d = 1'b1;
            bus_io_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d    = ST_WAIT;
        cnt_d      = 8'd0;
        ack_held_d = 1'b0;
      end
      ST_WAIT: begin
        if (ack_seen_s && min_reached_s) begin
          state_d = ST_HOLD;
          if (!bus_we_q) begin
            d_out_d = ack_data_s;
            d_oe_d  = 1'b1;
          end else begin
            d_oe_d  = 1'b0;
          end
        end else if (!ack_seen_s && (cnt_q == TO_LAST)) begin
          state_d   = ST_HOLD;
          timeout_d = 1'b1;
          if (!bus_we_q) begin
            d_out_d = 8'hFF;
            d_oe_d  = 1'b1;
          end else begin
            d_oe_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (bus_ack) begin
            ack_held_d   = 1'b1;
            rdata_held_d = bus_rdata;
          end else begin
            ack_held_d   = ack_held_q;
          end
        end
      end
      ST_HOLD: begin
        if (all_high_s) begin
          state_d = ST_IDLE;
          d_oe_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        d_oe_d  = 1'b0;
      end
    endcase

    // A new request wins over the acknowledge that would clear it
    if (int_req) begin
      nint_d = 1'b0;
    end else if (inta_entry_s) begin
      nint_d = 1'b1;
    end else begin
      nint_d = nint_q;
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Testbench for z80_bus_responder: two instances with different MIN_WAIT and
// TIMEOUT share one CPU/backend stimulus and are checked cycle by cycle
// against expectations derived from the bus-cycle rules.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        int_req;
  logic [7:0]  int_vector;

  logic [7:0]  dout_w  [2];
  logic        doe_w   [2];
  logic        nwait_w [2];
  logic        nint_w  [2];
  logic        req_w   [2];
  logic        we_w    [2];
  logic        io_w    [2];
  logic [15:0] addr_w  [2];
  logic [7:0]  wdata_w [2];
  logic        to_w    [2];

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  bit  pend     = 1'b0;

  always #5 clk = ~clk;

  z80_bus_responder #(.MIN_WAIT(0), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .reset(reset), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in),
    .D_out(dout_w[0]), .D_oe(doe_w[0]), .nWAIT(nwait_w[0]), .nINT(nint_w[0]),
    .bus_req(req_w[0]), .bus_we(we_w[0]), .bus_io(io_w[0]), .bus_addr(addr_w[0]),
    .bus_wdata(wdata_w[0]), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .int_req(int_req), .int_vector(int_vector), .timeout(to_w[0])
  );

  z80_bus_responder #(.MIN_WAIT(4), .TIMEOUT(12)) u_dut1 (
    .clk(clk), .reset(reset), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in),
    .D_out(dout_w[1]), .D_oe(doe_w[1]), .nWAIT(nwait_w[1]), .nINT(nint_w[1]),
    .bus_req(req_w[1]), .bus_we(we_w[1]), .bus_io(io_w[1]), .bus_addr(addr_w[1]),
    .bus_wdata(wdata_w[1]), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .int_req(int_req), .int_vector(int_vector), .timeout(to_w[1])
  );

  localparam int MINW [2] = '{0, 4};
  localparam int TMO  [2] = '{8, 12};

  typedef struct {
    int          kind;     // 0 MRD, 1 MWR, 2 IORD, 3 IOWR
    logic [15:0] addr;
    logic [7:0]  wd;
    int          ack_cyc;  // cycle index of the ack pulse, 255 = none
    logic [7:0]  rd;
    int          x0;       // WAIT index at which dut0 leaves WAIT
    bit          t0;
    int          x1;
    bit          t1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[dut%0d]: got %h expected %h at %0t", nm, d, act, exp, $time);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    bus_ack = 1'b0; int_req = 1'b0;
  endtask

  // WAIT index at which a cycle completes, from the ack/MIN_WAIT/TIMEOUT rules
  function automatic int exit_idx(input int ack_cyc, input int minw, input int tmo, output bit timed);
    int k;
    k = ack_cyc - 3;
    if (ack_cyc >= 3 && k < tmo) begin
      timed = 1'b0;
      return (k > minw) ? k : minw;
    end
    timed = 1'b1;
    return tmo - 1;
  endfunction

  // Strobes released: D_oe persists two more cycles for reads, nothing else moves
  task automatic release_check(input bit drove);
    set_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rel_D_oe", d, doe_w[d], drove && (c < 2));
        chk("rel_nWAIT", d, nwait_w[d], 1'b1);
        chk("rel_bus_req", d, req_w[d], 1'b0);
      end
      next_cyc();
    end
  endtask

  task automatic do_access(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                           input int ack_cyc, input logic [7:0] rd,
                           input int x0, input bit t0, input int x1, input bit t1);
    int xe [2];
    bit te [2];
    bit is_rd;
    int n;
    xe[0] = x0; xe[1] = x1; te[0] = t0; te[1] = t1;
    is_rd = (kind == 0) || (kind == 2);
    n = 4 + ((x0 > x1) ? x0 : x1) + 1;
    A = addr; D_in = wd;
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        nMREQ = (kind < 2) ? 1'b0 : 1'b1;
        nIORQ = (kind >= 2) ? 1'b0 : 1'b1;
        nRD   = is_rd ? 1'b0 : 1'b1;
        nWR   = is_rd ? 1'b1 : 1'b0;
      end
      bus_ack   = (c == ack_cyc);
      bus_rdata = (c == ack_cyc) ? rd : 8'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("nWAIT", d, nwait_w[d], (c <= 3 + xe[d]) ? 1'b0 : 1'b1);
        chk("bus_req", d, req_w[d], c == 2);
        chk("timeout", d, to_w[d], (c == 4 + xe[d]) && te[d]);
        chk("D_oe", d, doe_w[d], is_rd && (c >= 4 + xe[d]));
        chk("nINT", d, nint_w[d], !pend);
        if (is_rd && c >= 4 + xe[d]) chk("D_out", d, dout_w[d], te[d] ? 8'hFF : rd);
        if (c == 3) begin
          chk("bus_addr", d, addr_w[d], addr);
          chk("bus_we", d, we_w[d], !is_rd);
          chk("bus_io", d, io_w[d], kind >= 2);
          chk("bus_wdata", d, wdata_w[d], wd);
        end
      end
      next_cyc();
    end
    release_check(is_rd);
  endtask

  task automatic pulse_int();
    int_req = 1'b1;
    next_cyc();
    int_req = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("nINT_raise", d, nint_w[d], 1'b0);
    pend = 1'b1;
    next_cyc();
  endtask

  task automatic do_inta(input logic [7:0] vec, input bit irq_at_entry, input bit nint_after);
    int_vector = vec;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        nM1 = 1'b0; nIORQ = 1'b0;
      end
      int_req = irq_at_entry && (c == 1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("inta_bus_req", d, req_w[d], 1'b0);
        chk("inta_nWAIT", d, nwait_w[d], 1'b1);
        chk("inta_D_oe", d, doe_w[d], c >= 2);
        chk("inta_nINT", d, nint_w[d], (c >= 2) ? nint_after : !pend);
        if (c >= 2) chk("inta_D_out", d, dout_w[d], vec);
      end
      next_cyc();
    end
    pend = !nint_after;
    release_check(1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 16'h1234, 8'h00, 5,   8'hA5, 2, 1'b0, 4,  1'b0};
    tbl[1] = '{3, 16'h00FE, 8'h07, 3,   8'h11, 0, 1'b0, 4,  1'b0};
    tbl[2] = '{0, 16'h2000, 8'h33, 255, 8'h44, 7, 1'b1, 11, 1'b1};
    tbl[3] = '{2, 16'h8001, 8'h00, 2,   8'h3C, 7, 1'b1, 11, 1'b1};
    tbl[4] = '{1, 16'hBEEF, 8'h5A, 13,  8'h00, 7, 1'b1, 10, 1'b0};
    tbl[5] = '{2, 16'h0042, 8'h00, 14,  8'h99, 7, 1'b1, 11, 1'b0};
    tbl[6] = '{0, 16'hFFFF, 8'hC3, 7,   8'h00, 4, 1'b0, 4,  1'b0};
    tbl[7] = '{1, 16'h0000, 8'hE1, 11,  8'h77, 7, 1'b1, 8,  1'b0};

    reset = 1'b1; A = 16'h0000; D_in = 8'h00; bus_rdata = 8'h00; int_vector = 8'h00;
    set_idle();
    next_cyc(); next_cyc(); next_cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_D_out", d, dout_w[d], 8'h00);
      chk("rst_D_oe", d, doe_w[d], 1'b0);
      chk("rst_nWAIT", d, nwait_w[d], 1'b1);
      chk("rst_nINT", d, nint_w[d], 1'b1);
      chk("rst_bus_req", d, req_w[d], 1'b0);
      chk("rst_bus_we", d, we_w[d], 1'b0);
      chk("rst_bus_io", d, io_w[d], 1'b0);
      chk("rst_bus_addr", d, addr_w[d], 16'h0000);
      chk("rst_bus_wdata", d, wdata_w[d], 8'h00);
      chk("rst_timeout", d, to_w[d], 1'b0);
    end
    next_cyc();
    reset = 1'b0;
    next_cyc(); next_cyc(); next_cyc();

    for (int i = 0; i < 8; i++)
      do_access(tbl[i].kind, tbl[i].addr, tbl[i].wd, tbl[i].ack_cyc, tbl[i].rd,
                tbl[i].x0, tbl[i].t0, tbl[i].x1, tbl[i].t1);

    // Interrupt: raise, acknowledge, then re-raise on the acknowledge edge
    pulse_int();
    next_cyc();
    do_inta(8'hC8, 1'b0, 1'b1);
    pulse_int();
    do_inta(8'h3E, 1'b1, 1'b0);
    do_inta(8'h71, 1'b0, 1'b1);

    // Refresh never starts a cycle
    nMREQ = 1'b0; nRFSH = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus_ack = (c == 2);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rfsh_bus_req", d, req_w[d], 1'b0);
        chk("rfsh_nWAIT", d, nwait_w[d], 1'b1);
        chk("rfsh_D_oe", d, doe_w[d], 1'b0);
      end
      next_cyc();
    end
    release_check(1'b0);

    // Reset during WAIT: the cycle is dropped, even when the backend acks later
    pulse_int();
    A = 16'h4321; nMREQ = 1'b0; nRD = 1'b0;
    for (int c = 0; c < 5; c++) next_cyc();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rstw_nWAIT", d, nwait_w[d], 1'b1);
      chk("rstw_D_oe", d, doe_w[d], 1'b0);
      chk("rstw_bus_addr", d, addr_w[d], 16'h0000);
      chk("rstw_nINT", d, nint_w[d], 1'b1);
      chk("rstw_timeout", d, to_w[d], 1'b0);
    end
    next_cyc();
    for (int c = 0; c < 6; c++) begin
      bus_ack = (c == 1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rstw_bus_req", d, req_w[d], 1'b0);
        chk("rstw_nWAIT_hold", d, nwait_w[d], 1'b1);
        chk("rstw_D_oe_hold", d, doe_w[d], 1'b0);
      end
      next_cyc();
    end
    release_check(1'b0);
    do_access(0, 16'h4321, 8'h00, 5, 8'h6E, 2, 1'b0, 4, 1'b0);

    // Randomized accesses against the completion-point model
    for (int i = 0; i < 30; i++) begin
      int kind, ack_cyc, x0, x1;
      bit t0, t1;
      kind    = int'($urandom_range(3, 0));
      ack_cyc = ($urandom_range(4, 0) == 0) ? 255 : int'($urandom_range(17, 0));
      x0 = exit_idx(ack_cyc, MINW[0], TMO[0], t0);
      x1 = exit_idx(ack_cyc, MINW[1], TMO[1], t1);
      do_access(kind, 16'($urandom), 8'($urandom), ack_cyc, 8'($urandom), x0, t0, x1, t1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
